// File: rtl/alu_rs_pkg.sv
// rtl/alu_rs_pkg.sv - shared widths, work_type layout and entry types for the ALU reservation station
package alu_rs_pkg;

  localparam int ROBSIZE  = 4;
  localparam int RS_DEPTH = 8;

  // work_type layout: bit 0 branch, bit 1 sub/sra, bits 4:2 funct3
  localparam int WT_BRANCH_BIT = 0;
  localparam int WT_ALT_BIT    = 1;
  localparam int WT_F3_LSB     = 2;

  typedef struct packed {
    logic               busy;
    logic [ROBSIZE-1:0] tag;
    logic [31:0]        val;
  } operand_t;

  typedef struct packed {
    logic               busy;
    logic [4:0]         work_type;
    operand_t           j;
    operand_t           k;
    logic [ROBSIZE-1:0] rob_id;
  } rs_entry_t;

  // Port 0 is checked first so it wins when both broadcasts carry the tag.
  function automatic operand_t cdb_snoop(
    operand_t op,
    logic c0_valid, logic [ROBSIZE-1:0] c0_tag, logic [31:0] c0_val,
    logic c1_valid, logic [ROBSIZE-1:0] c1_tag, logic [31:0] c1_val
  );
    operand_t r;
    r = op;
    if (op.busy) begin
      if (c0_valid && c0_tag == op.tag) begin
        r.busy = 1'b0;
        r.val  = c0_val;
      end else if (c1_valid && c1_tag == op.tag) begin
        r.busy = 1'b0;
        r.val  = c1_val;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/alu_rs_pick.sv
// rtl/alu_rs_pick.sv - lowest-index priority encoder with found flag
module alu_rs_pick #(
  parameter int N  = 8,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  output logic          found,
  output logic [IW-1:0] idx
);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        found = 1'b1;
        idx   = IW'(i);
      end
    end
  end

endmodule

// File: rtl/alu_rs.sv
// rtl/alu_rs.sv - ALU reservation station: buffers ops, snoops two CDB ports, issues one ready op per cycle
module alu_rs
  import alu_rs_pkg::*;
#(
  parameter int RS_SIZE = RS_DEPTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rdy,
  input  logic               flush,
  input  logic               issue_valid,
  input  logic [4:0]         issue_work_type,
  input  logic [31:0]        issue_vj,
  input  logic [31:0]        issue_vk,
  input  logic               issue_qj_busy,
  input  logic               issue_qk_busy,
  input  logic [ROBSIZE-1:0] issue_qj,
  input  logic [ROBSIZE-1:0] issue_qk,
  input  logic [ROBSIZE-1:0] issue_rob_id,
  output logic               full,
  input  logic               cdb0_valid,
  input  logic [ROBSIZE-1:0] cdb0_rob_id,
  input  logic [31:0]        cdb0_value,
  input  logic               cdb1_valid,
  input  logic [ROBSIZE-1:0] cdb1_rob_id,
  input  logic [31:0]        cdb1_value,
  output logic               alu_valid,
  output logic [4:0]         alu_work_type,
  output logic [31:0]        alu_r1,
  output logic [31:0]        alu_r2,
  output logic [ROBSIZE-1:0] alu_rob_id
);

  localparam int IW = $clog2(RS_SIZE);

  rs_entry_t          ent [RS_SIZE];
  rs_entry_t          new_ent;
  operand_t           new_j;
  operand_t           new_k;
  logic [RS_SIZE-1:0] busy_vec;
  logic [RS_SIZE-1:0] ready_vec;
  logic               free_found;
  logic               ready_found;
  logic [IW-1:0]      free_idx;
  logic [IW-1:0]      ready_idx;

  always_comb begin
    busy_vec  = '0;
    ready_vec = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      busy_vec[i]  = ent[i].busy;
      ready_vec[i] = ent[i].busy & ~ent[i].j.busy & ~ent[i].k.busy;
    end
  end

  assign full = &busy_vec;

  alu_rs_pick #(.N(RS_SIZE), .IW(IW)) u_free_pick (
    .req   (~busy_vec),
    .found (free_found),
    .idx   (free_idx)
  );

  alu_rs_pick #(.N(RS_SIZE), .IW(IW)) u_ready_pick (
    .req   (ready_vec),
    .found (ready_found),
    .idx   (ready_idx)
  );

  // Issue-cycle bypass: a pending operand whose producer broadcasts now is captured on entry.
  always_comb begin
    new_j.busy = issue_qj_busy;
    new_j.tag  = issue_qj;
    new_j.val  = issue_vj;
    new_k.busy = issue_qk_busy;
    new_k.tag  = issue_qk;
    new_k.val  = issue_vk;
    new_ent.busy      = 1'b1;
    new_ent.work_type = issue_work_type;
    new_ent.j = cdb_snoop(new_j, cdb0_valid, cdb0_rob_id, cdb0_value,
                          cdb1_valid, cdb1_rob_id, cdb1_value);
    new_ent.k = cdb_snoop(new_k, cdb0_valid, cdb0_rob_id, cdb0_value,
                          cdb1_valid, cdb1_rob_id, cdb1_value);
    new_ent.rob_id = issue_rob_id;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RS_SIZE; i++) ent[i] <= '0;
      alu_valid     <= 1'b0;
      alu_work_type <= '0;
      alu_r1        <= '0;
      alu_r2        <= '0;
      alu_rob_id    <= '0;
    end else if (rdy) begin
      if (flush) begin
        for (int i = 0; i < RS_SIZE; i++) ent[i].busy <= 1'b0;
        alu_valid <= 1'b0;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (ent[i].busy) begin
            ent[i].j <= cdb_snoop(ent[i].j, cdb0_valid, cdb0_rob_id, cdb0_value,
                                  cdb1_valid, cdb1_rob_id, cdb1_value);
            ent[i].k <= cdb_snoop(ent[i].k, cdb0_valid, cdb0_rob_id, cdb0_value,
                                  cdb1_valid, cdb1_rob_id, cdb1_value);
          end
        end
        alu_valid <= ready_found;
        if (ready_found) begin
          alu_work_type        <= ent[ready_idx].work_type;
          alu_r1               <= ent[ready_idx].j.val;
          alu_r2               <= ent[ready_idx].k.val;
          alu_rob_id           <= ent[ready_idx].rob_id;
          ent[ready_idx].busy  <= 1'b0;
        end
        // The free slot is never the dispatched one, so these writes cannot collide.
        if (issue_valid && !full && free_found) ent[free_idx] <= new_ent;
      end
    end
  end

endmodule

// File: tb/tb_alu_rs.sv
// tb/tb_alu_rs.sv - scoreboard bench for alu_rs against a slot-list reference model
module tb_alu_rs;
  import alu_rs_pkg::*;

  localparam int N = 8;
  localparam int R = ROBSIZE;

  logic         clk = 1'b0;
  logic         rst_n, rdy, flush, issue_valid;
  logic [4:0]   issue_work_type;
  logic [31:0]  issue_vj, issue_vk;
  logic         issue_qj_busy, issue_qk_busy;
  logic [R-1:0] issue_qj, issue_qk, issue_rob_id;
  logic         full;
  logic         cdb0_valid, cdb1_valid;
  logic [R-1:0] cdb0_rob_id, cdb1_rob_id;
  logic [31:0]  cdb0_value, cdb1_value;
  logic         alu_valid;
  logic [4:0]   alu_work_type;
  logic [31:0]  alu_r1, alu_r2;
  logic [R-1:0] alu_rob_id;

  alu_rs #(.RS_SIZE(N)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .flush(flush),
    .issue_valid(issue_valid), .issue_work_type(issue_work_type),
    .issue_vj(issue_vj), .issue_vk(issue_vk),
    .issue_qj_busy(issue_qj_busy), .issue_qk_busy(issue_qk_busy),
    .issue_qj(issue_qj), .issue_qk(issue_qk), .issue_rob_id(issue_rob_id),
    .full(full),
    .cdb0_valid(cdb0_valid), .cdb0_rob_id(cdb0_rob_id), .cdb0_value(cdb0_value),
    .cdb1_valid(cdb1_valid), .cdb1_rob_id(cdb1_rob_id), .cdb1_value(cdb1_value),
    .alu_valid(alu_valid), .alu_work_type(alu_work_type),
    .alu_r1(alu_r1), .alu_r2(alu_r2), .alu_rob_id(alu_rob_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           stamp;
    logic [4:0]   wt;
    logic [31:0]  r1;
    logic [31:0]  r2;
    logic [R-1:0] rob;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;

  bit           m_busy [N];
  logic [4:0]   m_wt   [N];
  bit           m_p1   [N];
  bit           m_p2   [N];
  logic [R-1:0] m_t1   [N];
  logic [R-1:0] m_t2   [N];
  logic [31:0]  m_v1   [N];
  logic [31:0]  m_v2   [N];
  logic [R-1:0] m_rob  [N];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit m_full();
    for (int i = 0; i < N; i++) if (!m_busy[i]) return 1'b0;
    return 1'b1;
  endfunction

  // Value an operand holds after this cycle's broadcasts; port 0 looked at first.
  function automatic logic [32:0] resolve(input bit p, input logic [R-1:0] t, input logic [31:0] v);
    if (!p) return {1'b0, v};
    if (cdb0_valid && cdb0_rob_id == t) return {1'b0, cdb0_value};
    if (cdb1_valid && cdb1_rob_id == t) return {1'b0, cdb1_value};
    return {1'b1, v};
  endfunction

  task automatic model_step();
    int pick;
    int fr;
    bit was_full;
    exp_t e;
    if (!rst_n || !rdy) return;
    if (flush) begin
      for (int i = 0; i < N; i++) m_busy[i] = 1'b0;
      return;
    end
    was_full = m_full();
    pick = -1;
    fr = -1;
    for (int i = 0; i < N; i++) begin
      if (pick < 0 && m_busy[i] && !m_p1[i] && !m_p2[i]) pick = i;
      if (fr < 0 && !m_busy[i]) fr = i;
    end
    if (pick >= 0) begin
      e.stamp = cyc + 1;
      e.wt = m_wt[pick];
      e.r1 = m_v1[pick];
      e.r2 = m_v2[pick];
      e.rob = m_rob[pick];
      sb.push_back(e);
      m_busy[pick] = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      if (m_busy[i]) begin
        {m_p1[i], m_v1[i]} = resolve(m_p1[i], m_t1[i], m_v1[i]);
        {m_p2[i], m_v2[i]} = resolve(m_p2[i], m_t2[i], m_v2[i]);
      end
    end
    if (issue_valid && !was_full && fr >= 0) begin
      m_busy[fr] = 1'b1;
      m_wt[fr]   = issue_work_type;
      m_t1[fr]   = issue_qj;
      m_t2[fr]   = issue_qk;
      m_rob[fr]  = issue_rob_id;
      {m_p1[fr], m_v1[fr]} = resolve(issue_qj_busy, issue_qj, issue_vj);
      {m_p2[fr], m_v2[fr]} = resolve(issue_qk_busy, issue_qk, issue_vk);
    end
  endtask

  task automatic idle_inputs();
    rdy = 1'b1; flush = 1'b0; issue_valid = 1'b0;
    issue_work_type = '0; issue_vj = '0; issue_vk = '0;
    issue_qj_busy = 1'b0; issue_qk_busy = 1'b0;
    issue_qj = '0; issue_qk = '0; issue_rob_id = '0;
    cdb0_valid = 1'b0; cdb0_rob_id = '0; cdb0_value = '0;
    cdb1_valid = 1'b0; cdb1_rob_id = '0; cdb1_value = '0;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    chk("full", {31'b0, full}, {31'b0, m_full()});
  endtask

  task automatic do_issue(input logic [4:0] wt, input logic [31:0] vj, input logic [31:0] vk,
                          input bit pj, input logic [R-1:0] tj, input bit pk,
                          input logic [R-1:0] tk, input logic [R-1:0] rob);
    issue_valid = 1'b1; issue_work_type = wt; issue_vj = vj; issue_vk = vk;
    issue_qj_busy = pj; issue_qj = tj; issue_qk_busy = pk; issue_qk = tk;
    issue_rob_id = rob;
    tick();
    idle_inputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Monitor: pops the scoreboard on every live edge and checks hold behaviour when rdy is low.
  logic         prev_v;
  logic [31:0]  prev_r1, prev_r2;
  logic [R-1:0] prev_rob;
  bit           live;
  exp_t         got;

  always begin
    @(posedge clk);
    cyc++;
    live = rst_n && rdy;
    #1;
    if (rst_n) begin
      if (live) begin
        if (alu_valid) begin
          if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_dispatch: got rob %h expected no dispatch (cycle %0d)", alu_rob_id, cyc);
          end else begin
            got = sb.pop_front();
            chk("dispatch_cycle", cyc, got.stamp);
            chk("alu_work_type", {27'b0, alu_work_type}, {27'b0, got.wt});
            chk("alu_r1", alu_r1, got.r1);
            chk("alu_r2", alu_r2, got.r2);
            chk("alu_rob_id", 32'(alu_rob_id), 32'(got.rob));
          end
        end else if (sb.size() > 0 && sb[0].stamp <= cyc) begin
          got = sb.pop_front();
          tests++;
          fails++;
          $display("FAIL missing_dispatch: got alu_valid 0 expected rob %h (cycle %0d)", got.rob, cyc);
        end
      end else begin
        chk("hold_valid", {31'b0, alu_valid}, {31'b0, prev_v});
        chk("hold_r1", alu_r1, prev_r1);
        chk("hold_r2", alu_r2, prev_r2);
        chk("hold_rob", 32'(alu_rob_id), 32'(prev_rob));
      end
    end
    prev_v = alu_valid; prev_r1 = alu_r1; prev_r2 = alu_r2; prev_rob = alu_rob_id;
  end

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    for (int i = 0; i < N; i++) m_busy[i] = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_alu_valid", {31'b0, alu_valid}, 32'd0);
    chk("rst_alu_r1", alu_r1, 32'd0);
    chk("rst_alu_r2", alu_r2, 32'd0);
    chk("rst_alu_rob", 32'(alu_rob_id), 32'd0);
    chk("rst_full", {31'b0, full}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // simple add
    do_issue(5'b00000, 32'd5, 32'd7, 0, 0, 0, 0, 4'd3);
    idle(3);
    // operand wakeup through port 1
    do_issue(5'b00001, 32'd0, 32'd1, 1, 4'd4, 0, 0, 4'd5);
    idle(2);
    cdb1_valid = 1'b1; cdb1_rob_id = 4'd4; cdb1_value = 32'h10;
    tick(); idle_inputs();
    idle(2);
    // issue-cycle bypass on port 0; port 1 carries a competing value
    cdb0_valid = 1'b1; cdb0_rob_id = 4'd6; cdb0_value = 32'hFFFF_FFFF;
    cdb1_valid = 1'b1; cdb1_rob_id = 4'd6; cdb1_value = 32'h1234_5678;
    do_issue(5'b01010, 32'd9, 32'd0, 0, 0, 1, 4'd6, 4'd7);
    idle(2);
    // fill to full
    for (int i = 0; i < N; i++) do_issue(5'(i), 32'(i), 32'(100 + i), 1, 4'd9, 0, 0, 4'(i));
    chk("full_after_fill", {31'b0, full}, 32'd1);
    idle(2);
    cdb1_valid = 1'b1; cdb1_rob_id = 4'd9; cdb1_value = 32'hABCD;
    tick(); idle_inputs();
    idle(10);
    // flush with three pending and one ready
    for (int i = 0; i < 3; i++) do_issue(5'd2, 32'd0, 32'd0, 1, 4'd2, 1, 4'd2, 4'(i));
    do_issue(5'd3, 32'd11, 32'd12, 0, 0, 0, 0, 4'd8);
    flush = 1'b1;
    tick(); idle_inputs();
    chk("flush_valid", {31'b0, alu_valid}, 32'd0);
    chk("flush_full", {31'b0, full}, 32'd0);
    cdb0_valid = 1'b1; cdb0_rob_id = 4'd2; cdb0_value = 32'h55;
    tick(); idle_inputs();
    idle(3);
    // stall with a ready entry
    do_issue(5'd4, 32'd21, 32'd22, 0, 0, 0, 0, 4'd10);
    rdy = 1'b0;
    idle(3);
    rdy = 1'b1;
    idle(3);

    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      idle_inputs();
      rdy = ($urandom_range(0, 9) != 0);
      flush = ($urandom_range(0, 80) == 0);
      if (!m_full() && $urandom_range(0, 1) == 1) begin
        issue_valid = 1'b1;
        issue_work_type = 5'($urandom);
        issue_vj = $urandom; issue_vk = $urandom;
        issue_qj_busy = ($urandom_range(0, 2) == 0); issue_qj = 4'($urandom_range(0, 7));
        issue_qk_busy = ($urandom_range(0, 2) == 0); issue_qk = 4'($urandom_range(0, 7));
        issue_rob_id = 4'($urandom);
      end
      if ($urandom_range(0, 1) == 1) begin
        cdb0_valid = 1'b1; cdb0_rob_id = 4'($urandom_range(0, 7)); cdb0_value = $urandom;
      end
      if ($urandom_range(0, 1) == 1) begin
        cdb1_valid = 1'b1; cdb1_rob_id = 4'($urandom_range(0, 7)); cdb1_value = $urandom;
      end
      tick();
    end
    idle_inputs();
    idle(2);
    flush = 1'b1;
    tick(); idle_inputs();
    idle(3);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_rs.md
# alu_rs

ALU reservation station: the issue-side initiator that feeds the `alu` execution unit. It buffers decoded ALU/branch operations from the dispatcher and captures pending operands from two common-data-bus (CDB) broadcast ports. Each cycle it issues at most one operand-complete entry to the ALU using the ALU's `valid / work_type / r1 / r2 / inst_rob_id` interface. It sits between the decoder/dispatcher and `alu`; the ALU's result port loops back as CDB port 0.

## Interface
- `RS_SIZE`, 8 — number of entries; power of two, 2..16.
- `clk`  in  1  — single clock; all state on its rising edge.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `rdy`  in  1  — global enable; low = freeze all state and outputs.
- `flush`  in  1  — misprediction clear.
- `issue_valid`  in  1  — a new entry is presented this cycle.
- `issue_work_type`  in  5  — ALU/branch opcode, passed through unchanged.
- `issue_vj`, `issue_vk`  in  32 each  — operand values, meaningful when the matching `*_busy` is 0.
- `issue_qj_busy`, `issue_qk_busy`  in  1 each  — operand still pending.
- `issue_qj`, `issue_qk`  in  `robsize` each  — ROB tag producing the pending operand.
- `issue_rob_id`  in  `robsize`  — destination ROB tag.
- `full`  out  1  — all entries busy; `issue_valid` must be 0 while high.
- `cdb0_valid`, `cdb1_valid`  in  1 each; `cdb0_rob_id`, `cdb1_rob_id`  in  `robsize`; `cdb0_value`, `cdb1_value`  in  32 — result broadcasts; port 0 is the ALU, port 1 is the load/store unit.
- `alu_valid`  out  1 — registered.
- `alu_work_type`  out  5 — registered.
- `alu_r1`, `alu_r2`  out  32 — registered.
- `alu_rob_id`  out  `robsize` — registered.

## Operation
- Per-entry state: `busy`, `work_type`, `vj`, `vk`, `qj_busy`, `qj`, `qk_busy`, `qk`, `rob_id`.
- **Issue:** when `issue_valid` is high and `full` is low, write the lowest-index free entry and set `busy=1`.
  - Same-cycle bypass per operand: if `issue_q*_busy` is set and a valid CDB port carries that tag, store its value and clear the busy bit.
  - If both CDB ports match, port 0 wins.
- **Wakeup:** each cycle, every busy entry with a pending operand whose tag matches a valid CDB port captures the value and clears that busy bit. Port 0 has priority.
- **Select:** an entry is ready when `busy & !qj_busy & !qk_busy`, evaluated on registered state. The lowest-index ready entry is chosen.
- **Dispatch:** on the edge, drive the chosen entry onto the `alu_*` registers, set `alu_valid=1`, and clear that entry's `busy`. With no ready entry, `alu_valid` goes to 0 and the other `alu_*` outputs hold.
- Issue and dispatch in the same cycle are independent. A freed slot becomes usable the next cycle only.
- `full` is combinational from the registered `busy` vector (AND of all entries). It does not account for a same-cycle dispatch.
- **Priority:** `rst_n` > `!rdy` (hold everything) > `flush` > normal operation.
- **Flush:** clear every `busy` and set `alu_valid=0` on the edge. Issue, wakeup and dispatch in that cycle are discarded.
- Issue while `full` is a protocol violation: the entry is dropped, and the bench asserts it never occurs.
- **Reset:** every `busy`=0 and all `alu_*` outputs are 0. `full` resets to 0.

## Timing
- Issue at edge N. The entry can be selected in cycle N+1 at the earliest, giving `alu_valid` after edge N+1 and the ALU result after edge N+2.
- CDB broadcast in cycle M wakes an operand at edge M. The entry can dispatch at edge M+1.
  - Back-to-back dependent ALU ops therefore have one bubble.
- Issue-cycle bypass gives an operand ready at issue the same timing as an entry issued already ready.
- Dispatch throughput is at most one per cycle.
- With `rdy` low, `alu_valid` and the data outputs hold their values. The ALU ignores them.
- A reset assertion mid-operation clears state immediately (asynchronously). Release is synchronous to `clk` via the usual reset synchroniser outside this block.

## Structure
- Shared `const.v` holds:
  - `` `robsize ``;
  - the 5-bit `work_type` field layout (bit 0 = branch, bit 1 = sub/sra, bits 4:2 = funct3);
  - the RS depth default.
- Sub-module `rs_pick`: parameterised lowest-index priority encoder returning a found flag and an index. It is instantiated twice, once for the free-slot search and once for the ready search.
- The top level holds the entry arrays, wakeup comparators (2 × 2 × `RS_SIZE`) and the output registers.

## Test plan
- **Reset then simple add:** reset, then issue `work_type=5'b00000`, vj=5, vk=7, both ready, rob 3. Expect at edge+2: `alu_valid=1`, r1=5, r2=7, `alu_rob_id=3`. Expect `alu_valid=0` the cycle after.
- **Operand wakeup:** issue with qj_busy, qj=4, vk=1. Two cycles later drive `cdb1_valid`, tag 4, value 0x10. Expect dispatch the following edge with r1=0x10, and no dispatch before it.
- **Issue bypass:** issue with qk tag 6 in the same cycle as `cdb0` tag 6, value 0xFFFFFFFF. Expect dispatch next cycle with r2=0xFFFFFFFF.
- **Fill to full:** issue 8 entries all waiting on tag 9. Expect `full=1` and no dispatch. Broadcast tag 9, then expect 8 consecutive dispatches in index order and `full` falling after the first.
- **Flush:** with 3 entries pending and one ready, assert `flush`. Expect `alu_valid=0` and `full=0` next cycle. A later broadcast causes no dispatch.
- **Stall:** with a ready entry, hold `rdy=0` for 3 cycles. Expect no state change. Dispatch occurs on the first edge with `rdy=1`.
